// File: rtl/tc_fetch_pkg.sv
// Shared definitions for the ROM stream fetcher: FSM state codes, the ROM size
// query address and a constant-evaluable clog2.
package tc_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StIdle  = 2'd0;
  localparam fetch_state_t StSize  = 2'd1;
  localparam fetch_state_t StFetch = 2'd2;
  localparam fetch_state_t StDrain = 2'd3;

  // Reading this address returns the file length instead of data.
  localparam logic [63:0] ROM_SIZE_ADDR = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int unsigned ROM_WORD_BYTES = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tc_byte_ring.sv
// Circular byte buffer: up to 8 bytes pushed and up to MAX_POP bytes popped per
// cycle, with a zero-masked read window of the oldest bytes.
module tc_byte_ring
  import tc_fetch_pkg::*;
#(
  parameter int unsigned BUF_BYTES = 16,
  parameter int unsigned MAX_POP   = 4,
  localparam int unsigned PW = clog2(BUF_BYTES),
  localparam int unsigned LW = PW + 1,
  localparam int unsigned CW = clog2(MAX_POP + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [63:0]          push_data_i,
  input  logic [3:0]           push_count_i,
  input  logic [CW-1:0]        pop_i,
  output logic [LW-1:0]        level_o,
  output logic [LW-1:0]        level_next_o,
  output logic [CW-1:0]        count_o,
  output logic [8*MAX_POP-1:0] window_o
);

  logic [7:0]    mem_q [BUF_BYTES];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q;
  logic [CW-1:0] eff_pop;
  logic [PW-1:0] rd_idx;

  always_comb begin
    count_o = (level_q >= LW'(MAX_POP)) ? CW'(MAX_POP) : level_q[CW-1:0];
    // Requests beyond what is presented are clamped rather than underflowing.
    eff_pop = (pop_i > count_o) ? count_o : pop_i;
    level_next_o = level_q + LW'(push_count_i) - LW'(eff_pop);
  end

  always_comb begin
    window_o = '0;
    rd_idx   = '0;
    for (int j = 0; j < int'(MAX_POP); j++) begin
      rd_idx = rd_ptr_q + PW'(j);
      if (CW'(j) < count_o) begin
        window_o[8*j +: 8] = mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < int'(ROM_WORD_BYTES); k++) begin
      if (4'(k) < push_count_i) begin
        mem_q[wr_ptr_q + PW'(k)] <= push_data_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(eff_pop);
      wr_ptr_q <= wr_ptr_q + PW'(push_count_i);
      level_q  <= level_next_o;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/tc_rom_stream_fetcher.sv
// Prefetcher in front of a file-backed byte ROM: queries the file length, then
// streams bytes from start_addr to end of file into a ring for a downstream decoder.
module tc_rom_stream_fetcher
  import tc_fetch_pkg::*;
#(
  parameter int unsigned BUF_BYTES = 16,
  parameter int unsigned MAX_POP   = 4,
  localparam int unsigned CW = clog2(MAX_POP + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [63:0]          start_addr,
  output logic                 rom_en,
  output logic [63:0]          rom_addr,
  input  logic [63:0]          rom_data,
  output logic [8*MAX_POP-1:0] out_data,
  output logic [CW-1:0]        out_count,
  input  logic [CW-1:0]        pop,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          file_size
);

  localparam int unsigned LW = clog2(BUF_BYTES) + 1;

  fetch_state_t  state_q, state_d;
  logic [63:0]   fetch_ptr_q, fetch_ptr_d;
  logic [63:0]   file_size_q, file_size_d;
  logic          done_q, done_d;
  logic [63:0]   remaining;
  logic [3:0]    fetch_n;
  logic [3:0]    push_count;
  logic          has_room;
  logic [LW-1:0] level, level_next;

  tc_byte_ring #(
    .BUF_BYTES(BUF_BYTES),
    .MAX_POP  (MAX_POP)
  ) u_ring (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_data_i (rom_data),
    .push_count_i(push_count),
    .pop_i       (pop),
    .level_o     (level),
    .level_next_o(level_next),
    .count_o     (out_count),
    .window_o    (out_data)
  );

  always_comb begin
    remaining = file_size_q - fetch_ptr_q;
    fetch_n   = (remaining >= 64'd8) ? 4'd8 : remaining[3:0];
    // Uses the pre-pop level so a full word always fits regardless of pop.
    has_room  = (level <= LW'(BUF_BYTES - ROM_WORD_BYTES));
  end

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    file_size_d = file_size_q;
    done_d      = 1'b0;
    rom_en      = 1'b0;
    rom_addr    = '0;
    push_count  = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          fetch_ptr_d = start_addr;
          state_d     = StSize;
        end
      end
      StSize: begin
        rom_en      = 1'b1;
        rom_addr    = ROM_SIZE_ADDR;
        file_size_d = rom_data;
        if (fetch_ptr_q >= rom_data) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (has_room) begin
          rom_en      = 1'b1;
          rom_addr    = fetch_ptr_q;
          push_count  = fetch_n;
          fetch_ptr_d = fetch_ptr_q + {60'd0, fetch_n};
          if (remaining <= 64'd8) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (level_next == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fetch_ptr_q <= '0;
      file_size_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      file_size_q <= file_size_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign file_size = file_size_q;

endmodule
